// File: rtl/rename_alloc_ctrl_if.sv
// Rename-stage allocation bundle: rename bundle in, freelist pull/return, allocation result out.
interface rename_alloc_ctrl_if #(
  parameter int unsigned PREG_W = 6
);
  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_need;
  logic [PREG_W:0]   fl_num_free;
  logic [1:0]        fl_num_pull;
  logic [PREG_W-1:0] fl_preg1;
  logic [PREG_W-1:0] fl_preg2;
  logic              out_valid;
  logic              out_ready;
  logic [1:0]        out_pvalid;
  logic [PREG_W-1:0] out_preg0;
  logic [PREG_W-1:0] out_preg1;

  // Drives the bundle (rename stage, freelist and downstream side).
  modport master (
    output flush, in_valid, in_need, fl_num_free, fl_preg1, fl_preg2, out_ready,
    input  in_ready, fl_num_pull, out_valid, out_pvalid, out_preg0, out_preg1
  );

  // The allocation controller.
  modport slave (
    input  flush, in_valid, in_need, fl_num_free, fl_preg1, fl_preg2, out_ready,
    output in_ready, fl_num_pull, out_valid, out_pvalid, out_preg0, out_preg1
  );
endinterface

// File: rtl/rename_alloc_ctrl.sv
// Physical-register allocation sequencer for the 2-wide rename stage.
// Accepts a bundle, pulls 0..2 pregs from the freelist, captures and steers them
// to the uop slots one cycle later, then holds the result until downstream takes it.
// Optional feature macro: RENAME_ALLOC_STATS_EN adds stall_cycles / pregs_allocated counters.
module rename_alloc_ctrl #(
  parameter int unsigned NUM_PREGS = 64,
  parameter int unsigned PREG_W    = $clog2(NUM_PREGS)
) (
  input  logic               clk,
  input  logic               reset,
  rename_alloc_ctrl_if.slave bus
`ifdef RENAME_ALLOC_STATS_EN
  ,
  output logic [31:0]        stall_cycles,
  output logic [31:0]        pregs_allocated
`endif
);

  typedef enum logic [1:0] {StIdle, StPend, StHold} state_e;

  state_e            state_q, state_d;
  logic [1:0]        need_q, need_d;
  logic              out_valid_q, out_valid_d;
  logic [1:0]        pvalid_q, pvalid_d;
  logic [PREG_W-1:0] preg0_q, preg0_d;
  logic [PREG_W-1:0] preg1_q, preg1_d;

  logic [1:0]        need_cnt;
  logic [PREG_W:0]   need_ext;
  logic [PREG_W:0]   pull_ext;
  logic              enough;
  logic              in_ready;
  logic              accept;
  logic [1:0]        num_pull;

  // Handshake and pull count; reset gates acceptance so no pull escapes while in reset.
  always_comb begin
    need_cnt = {1'b0, bus.in_need[0]} + {1'b0, bus.in_need[1]};
    need_ext = (PREG_W + 1)'(need_cnt);
    enough   = (bus.fl_num_free >= need_ext);
    in_ready = !reset && !bus.flush && enough &&
               ((state_q == StIdle) || ((state_q == StHold) && bus.out_ready));
    accept   = bus.in_valid && in_ready;
    num_pull = accept ? need_cnt : 2'd0;
    pull_ext = (PREG_W + 1)'(num_pull);
  end

  assign bus.in_ready    = in_ready;
  assign bus.fl_num_pull = num_pull;
  assign bus.out_valid   = out_valid_q;
  assign bus.out_pvalid  = pvalid_q;
  assign bus.out_preg0   = preg0_q;
  assign bus.out_preg1   = preg1_q;

  // Next-state: accept into PEND, steer freelist outputs in PEND, hand off from HOLD.
  always_comb begin
    state_d     = state_q;
    need_d      = need_q;
    out_valid_d = out_valid_q;
    pvalid_d    = pvalid_q;
    preg0_d     = preg0_q;
    preg1_d     = preg1_q;
    if (bus.flush) begin
      // Freelist outputs of a flushed PEND cycle are dropped; recovery reclaims them.
      state_d     = StIdle;
      out_valid_d = 1'b0;
      pvalid_d    = 2'b00;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            state_d = StPend;
            need_d  = bus.in_need;
          end
        end
        StPend: begin
          state_d     = StHold;
          out_valid_d = 1'b1;
          pvalid_d    = need_q;
          // A single pull always lands on fl_preg1, whichever slot asked for it.
          case (need_q)
            2'b01:   preg0_d = bus.fl_preg1;
            2'b10:   preg1_d = bus.fl_preg1;
            2'b11: begin
              preg0_d = bus.fl_preg1;
              preg1_d = bus.fl_preg2;
            end
            default: ;
          endcase
        end
        StHold: begin
          if (bus.out_ready) begin
            out_valid_d = 1'b0;
            if (accept) begin
              state_d = StPend;
              need_d  = bus.in_need;
            end else begin
              state_d = StIdle;
            end
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // FSM and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= StIdle;
      need_q      <= 2'b00;
      out_valid_q <= 1'b0;
      pvalid_q    <= 2'b00;
      preg0_q     <= '0;
      preg1_q     <= '0;
    end else begin
      state_q     <= state_d;
      need_q      <= need_d;
      out_valid_q <= out_valid_d;
      pvalid_q    <= pvalid_d;
      preg0_q     <= preg0_d;
      preg1_q     <= preg1_d;
    end
  end

`ifdef RENAME_ALLOC_STATS_EN
  logic [31:0] stall_q, stall_d;
  logic [31:0] alloc_q, alloc_d;
  logic [32:0] alloc_sum;

  // Saturating counters; flush deliberately does not clear them.
  always_comb begin
    stall_d = stall_q;
    if (bus.in_valid && !enough && !bus.flush && (state_q != StPend) && (stall_q != '1)) begin
      stall_d = stall_q + 32'd1;
    end
    alloc_sum = {1'b0, alloc_q} + 33'(num_pull);
    alloc_d   = alloc_sum[32] ? '1 : alloc_sum[31:0];
  end

  // Statistics registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_q <= '0;
      alloc_q <= '0;
    end else begin
      stall_q <= stall_d;
      alloc_q <= alloc_d;
    end
  end

  assign stall_cycles    = stall_q;
  assign pregs_allocated = alloc_q;
`endif

  // Never pull more than the freelist holds, and the free count never exceeds the pool.
  assert property (@(posedge clk) disable iff (reset) (pull_ext <= bus.fl_num_free))
    else $error("fl_num_pull exceeds fl_num_free");
  assert property (@(posedge clk) disable iff (reset)
                   (32'(bus.fl_num_free) <= NUM_PREGS))
    else $error("fl_num_free exceeds NUM_PREGS");

endmodule

// File: tb/tb_rename_alloc_ctrl.sv
// Bench for rename_alloc_ctrl: cycle model plus a scoreboard of accepted bundles.
module tb_rename_alloc_ctrl;
  localparam int unsigned NumPregs = 64;
  localparam int unsigned PregW    = 6;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  rename_alloc_ctrl_if #(.PREG_W(PregW)) bus ();

`ifdef RENAME_ALLOC_STATS_EN
  logic [31:0] stall_cycles;
  logic [31:0] pregs_allocated;
`endif

  rename_alloc_ctrl #(
    .NUM_PREGS(NumPregs),
    .PREG_W   (PregW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
`ifdef RENAME_ALLOC_STATS_EN
    ,
    .stall_cycles   (stall_cycles),
    .pregs_allocated(pregs_allocated)
`endif
  );

  typedef enum logic [1:0] {MIdle, MPend, MHold} mst_e;
  typedef struct packed {
    logic [1:0] need;
    logic [5:0] base;
  } rec_t;

  int checks   = 0;
  int failures = 0;

  mst_e        m_st;
  rec_t        sb[$];
  logic [5:0]  m_p0, m_p1;
  logic [1:0]  m_pv;
  logic [5:0]  fl_next;
  logic        fl_pend;
  logic [5:0]  fl_pend_base;
  int unsigned m_stall, m_alloc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic int unsigned popcnt(input logic [1:0] n);
    return 32'(n[0]) + 32'(n[1]);
  endfunction

  task automatic set_in(input logic v, input logic [1:0] need, input int unsigned free,
                        input logic ordy, input logic fl);
    bus.in_valid    = v;
    bus.in_need     = need;
    bus.fl_num_free = 7'(free);
    bus.out_ready   = ordy;
    bus.flush       = fl;
  endtask

  task automatic model_reset();
    m_st    = MIdle;
    m_p0    = '0;
    m_p1    = '0;
    m_pv    = '0;
    fl_pend = 1'b0;
    m_stall = 0;
    m_alloc = 0;
    sb.delete();
  endtask

  // One cycle: inputs already set at the falling edge; check just after, then advance.
  task automatic tick();
    int unsigned cnt;
    logic        enough, rdy, acc;
    rec_t        r;
    if (fl_pend) begin
      bus.fl_preg1 = fl_pend_base;
      bus.fl_preg2 = 6'(fl_pend_base + 6'd1);
    end else begin
      bus.fl_preg1 = 6'($urandom);
      bus.fl_preg2 = 6'($urandom);
    end
    #1;
    cnt    = popcnt(bus.in_need);
    enough = (32'(bus.fl_num_free) >= cnt);
    rdy    = !bus.flush && enough && (m_st == MIdle || (m_st == MHold && bus.out_ready));
    acc    = bus.in_valid && rdy;
    check("in_ready", 32'(bus.in_ready), 32'(rdy));
    check("fl_num_pull", 32'(bus.fl_num_pull), acc ? cnt : 0);
    check("out_valid", 32'(bus.out_valid), 32'(m_st == MHold));
    check("out_pvalid", 32'(bus.out_pvalid), 32'(m_pv));
    check("out_preg0", 32'(bus.out_preg0), 32'(m_p0));
    check("out_preg1", 32'(bus.out_preg1), 32'(m_p1));
    if (m_st == MHold && bus.out_ready && !bus.flush) begin
      if (sb.size() == 0) begin
        check("sb_nonempty", 32'(sb.size()), 32'd1);
      end else begin
        r = sb.pop_front();
        check("hs_pvalid", 32'(bus.out_pvalid), 32'(r.need));
        if (r.need == 2'b11) begin
          check("hs_preg0", 32'(bus.out_preg0), 32'(r.base));
          check("hs_preg1", 32'(bus.out_preg1), 32'(6'(r.base + 6'd1)));
        end else if (r.need == 2'b01) begin
          check("hs_preg0", 32'(bus.out_preg0), 32'(r.base));
        end else if (r.need == 2'b10) begin
          check("hs_preg1", 32'(bus.out_preg1), 32'(r.base));
        end
      end
    end
    if (bus.in_valid && !enough && !bus.flush && m_st != MPend) m_stall++;
    if (acc) m_alloc += cnt;
    fl_pend = 1'b0;
    if (bus.flush) begin
      if (m_st != MIdle && sb.size() > 0) void'(sb.pop_front());
      m_st = MIdle;
      m_pv = 2'b00;
    end else begin
      case (m_st)
        MIdle: if (acc) begin
          sb.push_back('{need: bus.in_need, base: fl_next});
          m_st = MPend;
        end
        MPend: begin
          if (sb.size() > 0) begin
            r = sb[0];
            if (r.need[0] && !r.need[1]) m_p0 = r.base;
            if (r.need[1] && !r.need[0]) m_p1 = r.base;
            if (r.need == 2'b11) begin
              m_p0 = r.base;
              m_p1 = 6'(r.base + 6'd1);
            end
            m_pv = r.need;
          end
          m_st = MHold;
        end
        default: if (bus.out_ready) begin
          if (acc) begin
            sb.push_back('{need: bus.in_need, base: fl_next});
            m_st = MPend;
          end else begin
            m_st = MIdle;
          end
        end
      endcase
    end
    if (acc) begin
      fl_pend      = 1'b1;
      fl_pend_base = fl_next;
      fl_next      = 6'(fl_next + 6'(cnt));
    end
    @(negedge clk);
  endtask

  initial begin
    model_reset();
    fl_next      = '0;
    fl_pend_base = '0;
    bus.fl_preg1 = '0;
    bus.fl_preg2 = '0;
    reset = 1'b1;
    set_in(1'b1, 2'b11, 64, 1'b1, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("rst_out_valid", 32'(bus.out_valid), 32'd0);
    check("rst_pvalid", 32'(bus.out_pvalid), 32'd0);
    check("rst_preg0", 32'(bus.out_preg0), 32'd0);
    check("rst_preg1", 32'(bus.out_preg1), 32'd0);
    check("rst_pull", 32'(bus.fl_num_pull), 32'd0);
    reset = 1'b0;

    // Two-preg bundle: freelist returns 0,1.
    tick();
    set_in(1'b0, 2'b00, 64, 1'b1, 1'b0);
    tick(); tick(); tick();

    // Slot-1-only bundle gets preg 5; slot 0 keeps its old value.
    fl_next = 6'd5;
    set_in(1'b1, 2'b10, 64, 1'b1, 1'b0);
    tick();
    set_in(1'b0, 2'b00, 64, 1'b1, 1'b0);
    tick(); tick(); tick();

    // Insufficient free registers for four cycles, then enough.
    set_in(1'b1, 2'b11, 1, 1'b1, 1'b0);
    repeat (4) tick();
`ifdef RENAME_ALLOC_STATS_EN
    check("stall_cycles_4", stall_cycles, 32'd4);
`endif
    set_in(1'b1, 2'b11, 2, 1'b1, 1'b0);
    tick();
    // Downstream stalls HOLD for three cycles, then back-to-back accept.
    set_in(1'b0, 2'b00, 64, 1'b0, 1'b0);
    tick();
    repeat (3) tick();
    set_in(1'b1, 2'b01, 64, 1'b1, 1'b0);
    tick();
    set_in(1'b0, 2'b00, 64, 1'b1, 1'b0);
    tick(); tick(); tick();

    // Flush in PEND, then flush in HOLD with out_ready.
    set_in(1'b1, 2'b11, 64, 1'b1, 1'b0);
    tick();
    set_in(1'b0, 2'b00, 64, 1'b1, 1'b1);
    tick();
    set_in(1'b0, 2'b00, 64, 1'b1, 1'b0);
    tick();
    set_in(1'b1, 2'b01, 64, 1'b1, 1'b0);
    tick();
    set_in(1'b0, 2'b00, 64, 1'b1, 1'b0);
    tick();
    set_in(1'b0, 2'b00, 64, 1'b1, 1'b1);
    tick();
    set_in(1'b0, 2'b00, 64, 1'b1, 1'b0);
    tick();

    // Empty bundle passes through even with no free registers.
    set_in(1'b1, 2'b00, 0, 1'b1, 1'b0);
    tick();
    set_in(1'b0, 2'b00, 0, 1'b1, 1'b0);
    tick(); tick(); tick();

    // Asynchronous reset in the middle of PEND.
    set_in(1'b1, 2'b11, 64, 1'b1, 1'b0);
    tick();
    #2;
    reset = 1'b1;
    #1;
    check("amid_out_valid", 32'(bus.out_valid), 32'd0);
    check("amid_pull", 32'(bus.fl_num_pull), 32'd0);
    check("amid_in_ready", 32'(bus.in_ready), 32'd0);
    check("amid_preg0", 32'(bus.out_preg0), 32'd0);
    model_reset();
    @(negedge clk);
    reset   = 1'b0;
    fl_next = '0;
    tick();
    set_in(1'b0, 2'b00, 64, 1'b1, 1'b0);
    tick(); tick(); tick();

    // Random traffic.
    for (int i = 0; i < 400; i++) begin
      set_in(($urandom_range(0, 3) != 0), 2'($urandom),
             ($urandom_range(0, 3) == 0) ? 64 : $urandom_range(0, 3),
             ($urandom_range(0, 2) != 0), ($urandom_range(0, 15) == 0));
      tick();
    end
    set_in(1'b0, 2'b00, 64, 1'b1, 1'b0);
    tick(); tick();

`ifdef RENAME_ALLOC_STATS_EN
    check("stall_cycles", stall_cycles, m_stall);
    check("pregs_allocated", pregs_allocated, m_alloc);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/rename_alloc_ctrl.md
Name: rename_alloc_ctrl

Overview:
Sequences physical-register allocation from the freelist for the 2-wide rename stage. Accepts a rename bundle of up to two uops via valid/ready and computes the freelist pull count. Captures the allocated pregs one cycle later and steers them to the correct uop slot. Presents the result downstream via valid/ready, stalls when free registers are insufficient, and discards in-flight work on flush.

Parameters:
NUM_PREGS, 64, physical register count; must match the freelist instance.
PREG_W, $clog2(NUM_PREGS), preg index width.

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
flush  in  1  pipeline flush (branch mispredict / exception)
in_valid  in  1  rename bundle valid
in_ready  out  1  bundle accepted when in_valid && in_ready
in_need  in  2  bit k = uop slot k needs a destination preg
fl_num_free  in  PREG_W+1  freelist free count (combinational, current cycle)
fl_num_pull  out  2  pull request to freelist (0, 1 or 2)
fl_preg1  in  PREG_W  first allocated preg, valid the cycle after a pull>=1
fl_preg2  in  PREG_W  second allocated preg, valid the cycle after a pull==2
out_valid  out  1  allocation result valid
out_ready  in  1  downstream accepts result
out_pvalid  out  2  bit k = out_preg_k carries an allocated preg
out_preg0  out  PREG_W  preg for slot 0
out_preg1  out  PREG_W  preg for slot 1

Behaviour:
- FSM states: IDLE, PEND (pull issued, awaiting freelist outputs), HOLD (result held for downstream).
- need_cnt = popcount(in_need); enough = (fl_num_free >= need_cnt).
- in_ready = !flush && enough && (state==IDLE || (state==HOLD && out_ready)). in_ready = 0 in PEND.
- accept = in_valid && in_ready. fl_num_pull = accept ? need_cnt : 0. It is combinational and never nonzero without accept.
- On accept: latch in_need into need_q; state -> PEND.
- PEND -> HOLD unconditionally next cycle. Capture steering:
  - need_q=01 -> preg0=fl_preg1.
  - need_q=10 -> preg1=fl_preg1.
  - need_q=11 -> preg0=fl_preg1, preg1=fl_preg2.
  - need_q=00 -> no capture; pregs keep their old value.
  - out_pvalid=need_q.
- HOLD: out_valid=1. If out_ready && !accept -> IDLE. If out_ready && accept -> PEND (back-to-back). If !out_ready -> stay, all outputs stable.
- Throughput: one bundle per 2 cycles (accept, PEND, overlapped HOLD/accept).
- Latency: accept in cycle N -> out_valid in cycle N+2.
- need_cnt=0 bundles pass through with out_pvalid=00 and fl_num_pull=0. No free-count check applies (always enough).
- Insufficient free (fl_num_free < need_cnt): in_ready=0, no pull, state unchanged. Partial allocation is never performed.
- flush (synchronous effect): state -> IDLE, out_valid=0, out_pvalid=00 next cycle; same cycle in_ready=0, fl_num_pull=0.
  - Flush in PEND: freelist outputs of that cycle are ignored.
  - Pregs pulled but not delivered are reclaimed by the recovery logic, not by this block.
- flush && out_ready in HOLD: flush wins; no handshake is counted.
- Reset (async): state=IDLE, out_valid=0, out_pvalid=00, out_preg0=out_preg1=0, need_q=00. Combinationally, fl_num_pull=0.
- Assertion (sim only): fl_num_pull <= fl_num_free every cycle.

Optional Feature:
RENAME_ALLOC_STATS_EN:
- Defined: adds output stall_cycles (32 bits) and output pregs_allocated (32 bits).
  - stall_cycles increments each cycle with in_valid && !enough && !flush and state != PEND.
  - pregs_allocated adds fl_num_pull each cycle.
  - Both saturate at all-ones, reset to 0 asynchronously, and are unaffected by flush.
- Undefined: ports and counters absent; no other behaviour changes.

Test Plan:
- Reset, then in_valid=1, in_need=11, fl_num_free=64 -> fl_num_pull=2 in cycle 0. Freelist returns 0,1 in cycle 1 -> out_valid in cycle 2 with out_preg0=0, out_preg1=1, out_pvalid=11.
- in_need=10, fl_preg1=5 -> out_preg1=5, out_pvalid=10, out_preg0 unchanged.
- fl_num_free=1, in_need=11 held 4 cycles -> in_ready=0, fl_num_pull=0 throughout. With stats enabled, stall_cycles=4. Raising fl_num_free to 2 -> accept next cycle.
- HOLD with out_ready=0 for 3 cycles -> out_valid and pregs stable. out_ready=1 with new in_valid -> same-cycle accept, state PEND.
- Flush asserted in PEND -> next cycle out_valid=0, state IDLE. Flush in HOLD with out_ready=1 -> no handshake.
- Assert reset mid-PEND (async, between edges) -> out_valid=0, fl_num_pull=0 immediately. After release, first accept behaves as scenario 1.
